// File: rtl/bit_buffer.sv
// bit_buffer: single-bit serial delay buffer.
// Captures `in` on every rising edge into a DEPTH-bit shift register and
// exposes the history, the oldest sample, a fill status and 0->1 / 1->0
// edge decodes of the two newest samples. All outputs come from registers
// (directly, or through small decodes of register bits), so nothing leads
// combinationally from `in` to an output.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears history and fill count
//   in     serial data bit, sampled every posedge
//   out    oldest sample, buff[DEPTH-1]
//   buff   sample history, bit 0 newest, bit DEPTH-1 oldest
//   valid  high once DEPTH samples captured since last reset
//   rise   buff[1:0] == 2'b01
//   fall   buff[1:0] == 2'b10
module bit_buffer #(
  parameter int DEPTH = 4  // legal 2..32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic             out,
  output logic [DEPTH-1:0] buff,
  output logic             valid,
  output logic             rise,
  output logic             fall
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] fill;

  always_ff @(posedge clk) begin
    if (reset) begin
      buff <= '0;
      fill <= '0;
    end else begin
      buff <= {buff[DEPTH-2:0], in};
      // Saturate so valid never drops until the next reset.
      if (fill != FULL) fill <= fill + CW'(1);
    end
  end

  assign out   = buff[DEPTH-1];
  assign valid = (fill == FULL);
  // Mutually exclusive by construction: they need opposite values of buff[0].
  assign rise  =  buff[0] & ~buff[1];
  assign fall  = ~buff[0] &  buff[1];

endmodule

// File: tb/tb_bit_buffer.sv
module tb_bit_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic       rst4, in4, out4, valid4, rise4, fall4;
  logic [3:0] buff4;
  // DEPTH=2 instance
  logic       rst2, in2, out2, valid2, rise2, fall2;
  logic [1:0] buff2;

  bit_buffer #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(rst4), .in(in4), .out(out4), .buff(buff4),
    .valid(valid4), .rise(rise4), .fall(fall4));

  bit_buffer #(.DEPTH(2)) dut2 (
    .clk(clk), .reset(rst2), .in(in2), .out(out2), .buff(buff2),
    .valid(valid2), .rise(rise2), .fall(fall2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       din;
    logic [3:0] buff;
    logic       valid;
    logic       rise;
    logic       fall;
  } vec_t;

  vec_t vecs[26];

  task automatic step4(input logic r, input logic d);
    rst4 = r; in4 = d;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic r, input logic d);
    rst2 = r; in2 = d;
    @(posedge clk); #1;
  endtask

  initial begin
    // rst, in, buff, valid, rise, fall  (state after the edge)
    // reset held 2 edges with in=1
    vecs[0]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    // alternating 0,1,0,1
    vecs[2]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 4'b0101, 1'b1, 1'b1, 1'b0};
    // latency: reset, single pulse walks to out
    vecs[6]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};
    // constant 1 for 6 cycles
    vecs[12] = '{1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
    // build 1011, then mid-operation reset with in=1 and refill
    vecs[18] = '{1'b0, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 4'b1101, 1'b1, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};

    rst4 = 1'b1; in4 = 1'b0;
    rst2 = 1'b1; in2 = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      step4(vecs[i].rst, vecs[i].din);
      chk($sformatf("v%0d buff", i),  32'(buff4),  32'(vecs[i].buff));
      chk($sformatf("v%0d out", i),   32'(out4),   32'(vecs[i].buff[3]));
      chk($sformatf("v%0d valid", i), 32'(valid4), 32'(vecs[i].valid));
      chk($sformatf("v%0d rise", i),  32'(rise4),  32'(vecs[i].rise));
      chk($sformatf("v%0d fall", i),  32'(fall4),  32'(vecs[i].fall));
    end

    // Long run: valid must stay high (counter saturates, no wrap) and the
    // history must track a simple shift model for arbitrary data.
    begin
      logic [3:0] m;
      logic       d;
      m = 4'b1111;
      for (int i = 0; i < 40; i++) begin
        d = 1'($urandom_range(0, 1));
        step4(1'b0, d);
        m = {m[2:0], d};
        chk($sformatf("run%0d buff", i),  32'(buff4),  32'(m));
        chk($sformatf("run%0d valid", i), 32'(valid4), 32'd1);
        chk($sformatf("run%0d rise", i),  32'(rise4),  32'(m[0] & ~m[1]));
        chk($sformatf("run%0d fall", i),  32'(fall4),  32'(~m[0] & m[1]));
      end
    end

    // DEPTH=2: in=1,1 after reset
    step2(1'b1, 1'b1);
    chk("d2 rst buff",  32'(buff2),  32'd0);
    chk("d2 rst valid", 32'(valid2), 32'd0);
    step2(1'b0, 1'b1);
    chk("d2 e1 buff",  32'(buff2),  32'b01);
    chk("d2 e1 out",   32'(out2),   32'd0);
    chk("d2 e1 valid", 32'(valid2), 32'd0);
    chk("d2 e1 rise",  32'(rise2),  32'd1);
    step2(1'b0, 1'b1);
    chk("d2 e2 buff",  32'(buff2),  32'b11);
    chk("d2 e2 out",   32'(out2),   32'd1);
    chk("d2 e2 valid", 32'(valid2), 32'd1);
    chk("d2 e2 rise",  32'(rise2),  32'd0);
    step2(1'b0, 1'b0);
    chk("d2 e3 buff",  32'(buff2),  32'b10);
    chk("d2 e3 fall",  32'(fall2),  32'd1);
    chk("d2 e3 valid", 32'(valid2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
